// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
//
// Read-port consumer for the instruction RAM. It owns the program counter,
// drives the RAM address, and absorbs the RAM's one-cycle registered read
// latency. Each fetched word is split into an opcode and an operand and
// offered to the control unit over a valid/ready handshake. The unit follows
// jumps, and it stops fetching once it accepts the end-of-program opcode.
//
// With instr_ready held high, the unit delivers one instruction every three
// cycles (ISSUE -> WAIT -> VALID).
//
// Optional feature: define FETCH_PERF_CNT_EN to add a saturating 16-bit
// count of accepted handshakes on the fetch_count port.
//
// Ports
//   clk          in   system clock, rising edge
//   reset        in   asynchronous, active-high reset
//   mem_address  out  registered address to instruction RAM (== pc)
//   mem_instr    in   RAM read data, valid one cycle after address sampled
//   instr_valid  out  opcode/operand hold a fetched instruction
//   instr_ready  in   control unit accepts the instruction this cycle
//   opcode       out  registered mem_instr[15:10]
//   operand      out  registered mem_instr[9:0]
//   jump_en      in   take jump; sampled only on handshake
//   jump_target  in   next pc when jump_en
//   halted       out  HALT_OPCODE accepted; fetching stopped
//   fetch_count  out  accepted-handshake count (FETCH_PERF_CNT_EN only)
// ---------------------------------------------------------------------------
module instruction_fetch_unit #(
    parameter int ADDR_WIDTH   = 8,
    parameter int INSTR_WIDTH  = 16,
    parameter int OPCODE_WIDTH = 6,
    parameter int HALT_OPCODE  = 46
) (
    input  logic                                clk,
    input  logic                                reset,
    output logic [ADDR_WIDTH-1:0]               mem_address,
    input  logic [INSTR_WIDTH-1:0]              mem_instr,
    output logic                                instr_valid,
    input  logic                                instr_ready,
    output logic [OPCODE_WIDTH-1:0]             opcode,
    output logic [INSTR_WIDTH-OPCODE_WIDTH-1:0] operand,
    input  logic                                jump_en,
    input  logic [ADDR_WIDTH-1:0]               jump_target,
    output logic                                halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0]                         fetch_count
`endif
);

    localparam int                       OPERAND_WIDTH = INSTR_WIDTH - OPCODE_WIDTH;
    localparam logic [OPCODE_WIDTH-1:0]  HALT_OP       = OPCODE_WIDTH'(HALT_OPCODE);

    typedef enum logic [1:0] {
        S_ISSUE,  // address on the bus; RAM samples it at the next edge
        S_WAIT,   // RAM data arrives; capture it at the next edge
        S_VALID,  // instruction offered to the control unit
        S_HALT    // end-of-program accepted; frozen until reset
    } state_e;

    state_e                     state_q, state_d;
    logic [ADDR_WIDTH-1:0]      pc_q, pc_d;
    logic [OPCODE_WIDTH-1:0]    opcode_q, opcode_d;
    logic [OPERAND_WIDTH-1:0]   operand_q, operand_d;
    logic                       valid_q, valid_d;
    logic                       halted_q, halted_d;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0]                count_q, count_d;
`endif

    // The pc register feeds the RAM address directly, so the address only
    // changes on the edge that enters ISSUE and stays stable through WAIT.
    assign mem_address = pc_q;
    assign instr_valid = valid_q;
    assign opcode      = opcode_q;
    assign operand     = operand_q;
    assign halted      = halted_q;
`ifdef FETCH_PERF_CNT_EN
    assign fetch_count = count_q;
`endif

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d   = state_q;
        pc_d      = pc_q;
        opcode_d  = opcode_q;
        operand_d = operand_q;
        valid_d   = valid_q;
        halted_d  = halted_q;
`ifdef FETCH_PERF_CNT_EN
        count_d   = count_q;
`endif
        unique case (state_q)
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                opcode_d  = mem_instr[INSTR_WIDTH-1 -: OPCODE_WIDTH];
                operand_d = mem_instr[OPERAND_WIDTH-1:0];
                valid_d   = 1'b1;
                state_d   = S_VALID;
            end
            S_VALID: begin
                if (instr_ready) begin
                    valid_d = 1'b0;
`ifdef FETCH_PERF_CNT_EN
                    if (count_q != 16'hFFFF) begin
                        count_d = count_q + 16'd1;
                    end
`endif
                    // The halt opcode wins over a simultaneous jump request.
                    if (opcode_q == HALT_OP) begin
                        halted_d = 1'b1;
                        state_d  = S_HALT;
                    end else begin
                        // Sequential fetch wraps naturally at 2^ADDR_WIDTH.
                        pc_d    = jump_en ? jump_target : pc_q + ADDR_WIDTH'(1);
                        state_d = S_ISSUE;
                    end
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_ISSUE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values, regardless of the order the processes run in.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_ISSUE;
            pc_q      <= '0;
            opcode_q  <= '0;
            operand_q <= '0;
            valid_q   <= 1'b0;
            halted_q  <= 1'b0;
`ifdef FETCH_PERF_CNT_EN
            count_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            opcode_q  <= opcode_d;
            operand_q <= operand_d;
            valid_q   <= valid_d;
            halted_q  <= halted_d;
`ifdef FETCH_PERF_CNT_EN
            count_q   <= count_d;
`endif
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch_unit
//
// Drives instruction_fetch_unit from a 1-cycle-latency RAM model. A
// transaction-level reference model tracks pc, the presented instruction, the
// halt flag and the accept count. A compare process checks every output on
// every falling edge. Directed phases pin the model against hand-computed
// values: the first fetches, backpressure, a jump, pc wrap, halt, and a reset
// taken mid-fetch. A randomized phase exercises the ready/jump mix.
// ---------------------------------------------------------------------------
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  mem_address;
    logic [15:0] mem_instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [5:0]  opcode;
    logic [9:0]  operand;
    logic        jump_en;
    logic [7:0]  jump_target;
    logic        halted;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] fetch_count;
`endif

    int checks = 0;
    int errors = 0;

    logic [15:0] ram [256];

    instruction_fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .mem_address (mem_address),
        .mem_instr   (mem_instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .opcode      (opcode),
        .operand     (operand),
        .jump_en     (jump_en),
        .jump_target (jump_target),
        .halted      (halted)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count (fetch_count)
`endif
    );

    always #5 clk = ~clk;

    // Instruction RAM: registered read, data valid one cycle after the address.
    always @(posedge clk) mem_instr <= ram[mem_address];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // A fetch of address pc presents ram[pc] two edges after it starts. An
    // accepted presentation either halts (on opcode 46) or starts the next
    // fetch from the jump target or from pc+1 mod 256.
    logic [7:0] m_pc;
    logic       m_valid;
    logic       m_halted;
    logic [5:0] m_op;
    logic [9:0] m_opd;
    int         m_wait;
    int         m_cnt;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pc     <= 8'd0;
            m_valid  <= 1'b0;
            m_halted <= 1'b0;
            m_op     <= 6'd0;
            m_opd    <= 10'd0;
            m_wait   <= 2;
            m_cnt    <= 0;
        end else if (!m_halted) begin
            if (m_valid) begin
                if (instr_ready) begin
                    m_valid <= 1'b0;
                    m_cnt   <= (m_cnt < 65535) ? m_cnt + 1 : m_cnt;
                    if (m_op == 6'd46) begin
                        m_halted <= 1'b1;
                    end else begin
                        m_pc   <= jump_en ? jump_target : 8'((int'(m_pc) + 1) % 256);
                        m_wait <= 2;
                    end
                end
            end else if (m_wait == 1) begin
                m_valid <= 1'b1;
                m_op    <= ram[m_pc][15:10];
                m_opd   <= ram[m_pc][9:0];
                m_wait  <= 0;
            end else begin
                m_wait <= m_wait - 1;
            end
        end
    end

    always @(negedge clk) begin
        check("mem_address", 32'(mem_address), 32'(m_pc));
        check("instr_valid", 32'(instr_valid), 32'(m_valid));
        check("halted",      32'(halted),      32'(m_halted));
        check("opcode",      32'(opcode),      32'(m_op));
        check("operand",     32'(operand),     32'(m_opd));
`ifdef FETCH_PERF_CNT_EN
        check("fetch_count", 32'(fetch_count), 32'(m_cnt));
`endif
    end

    // Advance at least one falling edge, then stop at the first one where an
    // instruction is presented; a missing presentation is reported as a failure.
    task automatic wait_valid();
        bit seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            seen = instr_valid;
        end
        if (!seen) check("valid_timeout", 32'd0, 32'd1);
    endtask

    int exp_op  [4] = '{3, 63, 0, 32};
    int exp_opd [4] = '{5, 1023, 0, 291};

    initial begin
        logic [15:0] w;
        reset       = 1'b1;
        instr_ready = 1'b0;
        jump_en     = 1'b0;
        jump_target = 8'd0;
        for (int i = 0; i < 256; i++) begin
            w = 16'($urandom);
            if (w[15:10] == 6'd46) w[15:10] = 6'd47;
            ram[i] = w;
        end
        ram[0]   = 16'h0C05;
        ram[1]   = 16'hFFFF;
        ram[2]   = 16'h0000;
        ram[3]   = 16'h8123;
        ram[143] = {6'd52, 10'd159};
        ram[164] = {6'd46, 10'd0};

        // Reset values, then the first four sequential fetches.
        repeat (3) @(negedge clk);
        check("rst_addr",  32'(mem_address), 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_op",    32'(opcode),      32'd0);
        instr_ready = 1'b1;
        reset       = 1'b0;
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < ((k == 0) ? 2 : 3); c++) begin
                @(negedge clk);
                check("seq_addr", 32'(mem_address), 32'(k));
                if (c == ((k == 0) ? 1 : 2)) begin
                    check("seq_valid",   32'(instr_valid), 32'd1);
                    check("seq_opcode",  32'(opcode),      32'(exp_op[k]));
                    check("seq_operand", 32'(operand),     32'(exp_opd[k]));
                end else begin
                    check("seq_notvalid", 32'(instr_valid), 32'd0);
                end
            end
        end

        // Backpressure on word 3 for five edges, accept on the sixth.
        instr_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("bp_valid", 32'(instr_valid), 32'd1);
            check("bp_addr",  32'(mem_address), 32'd3);
            check("bp_op",    32'(opcode),      32'd32);
        end
        instr_ready = 1'b1;
        @(negedge clk);
        check("bp_next_addr", 32'(mem_address), 32'd4);

        // Jump to 143, jump request held through ISSUE/WAIT with another target.
        wait_valid();
        jump_en     = 1'b1;
        jump_target = 8'd143;
        @(negedge clk);
        check("jmp143_addr", 32'(mem_address), 32'd143);
        jump_target = 8'd200;
        wait_valid();
        check("jmp143_addr_hold", 32'(mem_address), 32'd143);
        check("jmp_opcode",       32'(opcode),      32'd52);
        check("jmp_operand",      32'(operand),     32'd159);
        jump_target = operand[7:0];
        @(negedge clk);
        check("jmp159_addr", 32'(mem_address), 32'd159);

        // Wrap from 255 to 0.
        jump_en = 1'b0;
        wait_valid();
        jump_en     = 1'b1;
        jump_target = 8'd255;
        @(negedge clk);
        jump_en = 1'b0;
        wait_valid();
        check("wrap_pre", 32'(mem_address), 32'd255);
        @(negedge clk);
        check("wrap_post", 32'(mem_address), 32'd0);

        // Randomized ready/jump traffic kept below the halt word.
        repeat (150) begin
            @(negedge clk);
            instr_ready = ($urandom_range(3) != 0);
            jump_en     = ($urandom_range(3) == 0);
            jump_target = 8'($urandom_range(59));
        end

        // Halt: word 164 accepted together with a jump request.
        instr_ready = 1'b0;
        jump_en     = 1'b0;
        wait_valid();
        instr_ready = 1'b1;
        jump_en     = 1'b1;
        jump_target = 8'd164;
        @(negedge clk);
        jump_target = 8'd7;
        wait_valid();
        check("halt_opcode", 32'(opcode),      32'd46);
        check("halt_addr0",  32'(mem_address), 32'd164);
        @(negedge clk);
        check("halt_flag",  32'(halted),      32'd1);
        check("halt_valid", 32'(instr_valid), 32'd0);
        repeat (20) begin
            @(negedge clk);
            instr_ready = 1'($urandom);
            jump_en     = 1'($urandom);
            jump_target = 8'($urandom);
        end
        check("halt_addr20",  32'(mem_address), 32'd164);
        check("halt_flag20",  32'(halted),      32'd1);
        check("halt_valid20", 32'(instr_valid), 32'd0);

        // Reset out of HALT, then reset again while word 2 is in WAIT.
        reset = 1'b1;
        @(negedge clk);
        reset       = 1'b0;
        instr_ready = 1'b1;
        jump_en     = 1'b0;
        wait_valid();
        wait_valid();
        @(negedge clk);
        check("midwait_addr", 32'(mem_address), 32'd2);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("rst_now_addr",   32'(mem_address), 32'd0);
        check("rst_now_valid",  32'(instr_valid), 32'd0);
        check("rst_now_op",     32'(opcode),      32'd0);
        check("rst_now_opd",    32'(operand),     32'd0);
        check("rst_now_halted", 32'(halted),      32'd0);
`ifdef FETCH_PERF_CNT_EN
        check("rst_now_count",  32'(fetch_count), 32'd0);
`endif
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            wait_valid();
            check("refetch_addr", 32'(mem_address), 32'(k));
        end
        @(negedge clk);
        check("refetch_next", 32'(mem_address), 32'd5);
`ifdef FETCH_PERF_CNT_EN
        check("count5", 32'(fetch_count), 32'd5);
`endif
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
